// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the multicycle control unit
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_UNIMP  = 4'd10
  } state_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - condition evaluation, latched condex and NZCV register
module cond_unit
  import cpu_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       cond_latch,
  input  logic [1:0] flag_w,
  output logic [3:0] flags,
  output logic       condex
);

  logic n, z, c, v;
  logic cond_met;

  always_comb begin
    {n, z, c, v} = flags;
    cond_met = 1'b0;
    case (cond)
      COND_EQ: cond_met = z;
      COND_NE: cond_met = ~z;
      COND_CS: cond_met = c;
      COND_CC: cond_met = ~c;
      COND_MI: cond_met = n;
      COND_PL: cond_met = ~n;
      COND_VS: cond_met = v;
      COND_VC: cond_met = ~v;
      COND_HI: cond_met = c & ~z;
      COND_LS: cond_met = ~c | z;
      COND_GE: cond_met = (n == v);
      COND_LT: cond_met = (n != v);
      COND_GT: cond_met = ~z & (n == v);
      COND_LE: cond_met = z | (n != v);
      COND_AL: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  // flag_w[1] covers NZ, flag_w[0] covers CV so logical ops can keep C/V
  always_ff @(posedge clk) begin
    if (reset) begin
      flags  <= RESET_FLAGS;
      condex <= 1'b0;
    end else begin
      if (cond_latch) condex <= cond_met;
      if (flag_w[1])  flags[3:2] <= alu_flags[3:2];
      if (flag_w[0])  flags[1:0] <= alu_flags[1:0];
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle fetch/decode/execute sequencer for the ARM-like core
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemW,
  output logic       IRWrite,
  output logic       RegW,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] Flags,
  output logic [3:0] state_o
);

  state_t     state, state_next;
  logic       condex;
  logic       cond_latch;
  logic [1:0] flag_w;
  logic [1:0] dp_alu;
  logic [1:0] dp_flag_w;
  logic       pc_dest;

  cond_unit #(.RESET_FLAGS(RESET_FLAGS)) u_cond (
    .clk        (clk),
    .reset      (reset),
    .cond       (cond),
    .alu_flags  (ALUFlags),
    .cond_latch (cond_latch),
    .flag_w     (flag_w),
    .flags      (Flags),
    .condex     (condex)
  );

  assign pc_dest = (Rd == 4'd15);
  assign ImmSrc  = op;
  assign RegSrc  = {(op == OP_MEM) & ~funct[0], (op == OP_BR)};
  assign state_o = state;

  // unlisted data-processing opcodes compute ADD but never touch the flags
  always_comb begin
    dp_alu    = ALU_ADD;
    dp_flag_w = 2'b00;
    case (funct[4:1])
      4'b0100: begin dp_alu = ALU_ADD; dp_flag_w = 2'b11; end
      4'b0010: begin dp_alu = ALU_SUB; dp_flag_w = 2'b11; end
      4'b0000: begin dp_alu = ALU_AND; dp_flag_w = 2'b10; end
      4'b1100: begin dp_alu = ALU_ORR; dp_flag_w = 2'b10; end
      default: begin dp_alu = ALU_ADD; dp_flag_w = 2'b00; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemW       = 1'b0;
    IRWrite    = 1'b0;
    RegW       = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RD2;
    ALUControl = ALU_ADD;
    cond_latch = 1'b0;
    flag_w     = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALU;
        cond_latch = 1'b1;
        case (op)
          OP_DP:   state_next = funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  state_next = S_MEMADR;
          OP_BR:   state_next = S_BRANCH;
          default: state_next = S_UNIMP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        state_next = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_RDATA;
        RegW       = condex;
        PCWrite    = condex & pc_dest;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        // a failed condition skips the bus cycle entirely
        mem_req = condex;
        AdrSrc  = 1'b1;
        MemW    = condex;
        if (!condex || mem_ready) state_next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state == S_EXECI) ? SRCB_IMM : SRCB_RD2;
        ALUControl = dp_alu;
        flag_w     = (condex & funct[0]) ? dp_flag_w : 2'b00;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        RegW       = condex;
        PCWrite    = condex & pc_dest;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ResultSrc  = RES_ALU;
        PCWrite    = condex;
        state_next = S_FETCH;
      end
      S_UNIMP:  state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
    if (reset) begin
      mem_req    = 1'b0;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemW       = 1'b0;
      IRWrite    = 1'b0;
      RegW       = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_RD2;
      ALUControl = ALU_ADD;
      cond_latch = 1'b0;
      flag_w     = 2'b00;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       mem_ready;
  logic       mem_req, PCWrite, AdrSrc, MemW, IRWrite, RegW, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0] Flags, state_o;
  logic [12:0] act_ctl;

  int checks = 0;
  int errors = 0;
  logic [3:0] mflags;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .MemW(MemW), .IRWrite(IRWrite), .RegW(RegW), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .Flags(Flags), .state_o(state_o)
  );

  assign act_ctl = {mem_req, PCWrite, AdrSrc, MemW, IRWrite, RegW, ResultSrc,
                    ALUSrcA, ALUSrcB, ALUControl};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] fl);
    logic n, z, cc, v;
    {n, z, cc, v} = fl;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cc;
      4'h3: return !cc;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cc && !z;
      4'h9: return !cc || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_of(input logic [5:0] f);
    case (f[4:1])
      4'b0010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] flag_upd(input logic [3:0] fl, input logic pass,
                                          input logic [5:0] f, input logic [3:0] af);
    if (!(pass && f[0])) return fl;
    case (f[4:1])
      4'b0100, 4'b0010: return af;
      4'b0000, 4'b1100: return {af[3:2], fl[1:0]};
      default:          return fl;
    endcase
  endfunction

  // {mem_req,PCWrite,AdrSrc,MemW,IRWrite,RegW,ResultSrc,ALUSrcA,ALUSrcB,ALUControl}
  function automatic logic [12:0] exp_ctl(input state_t s, input logic pass, input logic [5:0] f,
                                          input logic [3:0] r, input logic rdy);
    logic mreq, pcw, adr, mw, irw, rw, srca;
    logic [1:0] res, srcb, alu;
    mreq = 0; pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; srca = 0;
    res = 2'b00; srcb = 2'b00; alu = 2'b00;
    case (s)
      S_FETCH:  begin mreq = 1; srca = 1; srcb = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
      S_DECODE: begin srca = 1; srcb = 2'b10; res = 2'b10; end
      S_MEMADR: srcb = 2'b01;
      S_MEMRD:  begin mreq = 1; adr = 1; end
      S_MEMWB:  begin res = 2'b01; rw = pass; pcw = pass && (r == 4'd15); end
      S_MEMWR:  begin mreq = pass; adr = 1; mw = pass; end
      S_EXECR:  begin srcb = 2'b00; alu = alu_of(f); end
      S_EXECI:  begin srcb = 2'b01; alu = alu_of(f); end
      S_ALUWB:  begin res = 2'b00; rw = pass; pcw = pass && (r == 4'd15); end
      S_BRANCH: begin srca = 1; srcb = 2'b01; res = 2'b10; pcw = pass; end
      default: ;
    endcase
    return {mreq, pcw, adr, mw, irw, rw, res, srca, srcb, alu};
  endfunction

  // Runs one instruction from FETCH; wait counts < 0 pick a random number of not-ready cycles
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] af, input int fw, input int mw,
                           output int ncyc, output logic [2:0] last);
    state_t q[$];
    state_t ph;
    logic pass, waits;
    int waitcnt, lim;
    cond = c; op = o; funct = f; Rd = r; ALUFlags = af;
    pass = cond_ok(c, mflags);
    q = {};
    q.push_back(S_FETCH);
    q.push_back(S_DECODE);
    case (o)
      2'b00: begin q.push_back(f[5] ? S_EXECI : S_EXECR); q.push_back(S_ALUWB); end
      2'b01: begin
        q.push_back(S_MEMADR);
        if (f[0]) begin q.push_back(S_MEMRD); q.push_back(S_MEMWB); end
        else q.push_back(S_MEMWR);
      end
      2'b10: q.push_back(S_BRANCH);
      default: q.push_back(S_UNIMP);
    endcase
    ncyc = 0; waitcnt = 0; lim = 0; last = 3'b000;
    while (q.size() != 0 && ncyc < 64) begin
      ph = q[0];
      waits = (ph == S_FETCH) || (ph == S_MEMRD) || (ph == S_MEMWR && pass);
      if (waits) begin
        if (waitcnt == 0) begin
          lim = (ph == S_FETCH) ? fw : mw;
          if (lim < 0) lim = $urandom_range(0, 3);
        end
        mem_ready = (waitcnt >= lim);
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #3;
      chk("state", state_o, ph);
      chk("ctl", act_ctl, exp_ctl(ph, pass, f, r, mem_ready));
      chk("flags", Flags, mflags);
      chk("immsrc", ImmSrc, o);
      chk("regsrc", RegSrc, {o == 2'b01 && !f[0], o == 2'b10});
      last = {RegW, PCWrite, MemW};
      if (waits && !mem_ready) begin
        waitcnt++;
      end else begin
        void'(q.pop_front());
        waitcnt = 0;
        if (ph == S_EXECR || ph == S_EXECI) mflags = flag_upd(mflags, pass, f, af);
      end
      tick();
      ncyc++;
    end
    chk("instr_done", q.size(), 0);
  endtask

  typedef struct {
    logic [3:0] c;
    logic [1:0] o;
    logic [5:0] f;
    logic [3:0] r;
    logic [3:0] af;
    int         cyc;
    logic [3:0] fl;
    logic [2:0] last;  // {RegW,PCWrite,MemW} in the final cycle
  } vec_t;

  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncyc;
    logic [2:0] last;

    tbl[0]  = '{4'hE, 2'b00, 6'b001001, 4'd1,  4'b0110, 4, 4'b0110, 3'b100};
    tbl[1]  = '{4'hE, 2'b00, 6'b001001, 4'd1,  4'b0011, 4, 4'b0011, 3'b100};
    tbl[2]  = '{4'hE, 2'b00, 6'b000001, 4'd3,  4'b1000, 4, 4'b1011, 3'b100};
    tbl[3]  = '{4'hE, 2'b00, 6'b000100, 4'd4,  4'b1111, 4, 4'b1011, 3'b100};
    tbl[4]  = '{4'hE, 2'b00, 6'b111001, 4'd5,  4'b0100, 4, 4'b0111, 3'b100};
    tbl[5]  = '{4'hE, 2'b00, 6'b100011, 4'd6,  4'b1000, 4, 4'b0111, 3'b100};
    tbl[6]  = '{4'hE, 2'b00, 6'b101000, 4'd15, 4'b0000, 4, 4'b0111, 3'b110};
    tbl[7]  = '{4'h0, 2'b10, 6'b000000, 4'd0,  4'b0000, 3, 4'b0111, 3'b010};
    tbl[8]  = '{4'hE, 2'b00, 6'b001001, 4'd1,  4'b0000, 4, 4'b0000, 3'b100};
    tbl[9]  = '{4'h0, 2'b10, 6'b000000, 4'd0,  4'b0000, 3, 4'b0000, 3'b000};
    tbl[10] = '{4'hE, 2'b01, 6'b011001, 4'd2,  4'b0000, 5, 4'b0000, 3'b100};
    tbl[11] = '{4'hE, 2'b01, 6'b011000, 4'd2,  4'b0000, 4, 4'b0000, 3'b001};
    tbl[12] = '{4'hF, 2'b00, 6'b001001, 4'd1,  4'b1111, 4, 4'b0000, 3'b000};
    tbl[13] = '{4'hE, 2'b11, 6'b000000, 4'd0,  4'b0000, 3, 4'b0000, 3'b000};
    tbl[14] = '{4'h1, 2'b00, 6'b001001, 4'd1,  4'b0100, 4, 4'b0100, 3'b100};
    tbl[15] = '{4'h1, 2'b01, 6'b011000, 4'd2,  4'b0000, 4, 4'b0100, 3'b000};

    reset = 1'b1; cond = 4'hE; op = 2'b10; funct = 6'd0; Rd = 4'd0;
    ALUFlags = 4'd0; mem_ready = 1'b0; mflags = 4'b0000;
    repeat (2) @(posedge clk);
    #4;
    chk("reset_state", state_o, S_FETCH);
    chk("reset_ctl", act_ctl, 13'd0);
    chk("reset_flags", Flags, 4'b0000);
    chk("reset_immsrc", ImmSrc, 2'b10);
    chk("reset_regsrc", RegSrc, 2'b01);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_instr(tbl[i].c, tbl[i].o, tbl[i].f, tbl[i].r, tbl[i].af, 0, 0, ncyc, last);
      chk($sformatf("vec%0d_cycles", i), ncyc, tbl[i].cyc);
      chk($sformatf("vec%0d_flags", i), Flags, tbl[i].fl);
      chk($sformatf("vec%0d_last", i), last, tbl[i].last);
    end

    run_instr(4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000, 0, 3, ncyc, last);
    chk("ldr_wait3_cycles", ncyc, 8);
    run_instr(4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000, 2, 3, ncyc, last);
    chk("ldr_pc_wait_cycles", ncyc, 10);
    chk("ldr_pc_last", last, 3'b110);
    run_instr(4'hE, 2'b01, 6'b011000, 4'd2, 4'b0000, 1, 2, ncyc, last);
    chk("str_wait_cycles", ncyc, 7);

    // reset while a load is stalled in MEMRD
    run_instr(4'hE, 2'b00, 6'b001001, 4'd1, 4'b1010, 0, 0, ncyc, last);
    chk("pre_reset_flags", Flags, 4'b1010);
    cond = 4'hE; op = 2'b01; funct = 6'b011001; Rd = 4'd2; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #3;
    chk("memrd_state", state_o, S_MEMRD);
    chk("memrd_req", mem_req, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    #3;
    chk("abort_state", state_o, S_FETCH);
    chk("abort_mem_req", mem_req, 1'b0);
    chk("abort_flags", Flags, 4'b0000);
    tick();
    reset = 1'b0;
    mflags = 4'b0000;

    for (int i = 0; i < 60; i++) begin
      logic [3:0] rc, rr, raf;
      logic [1:0] ro;
      logic [5:0] rf;
      rc  = 4'($urandom_range(0, 15));
      ro  = 2'($urandom_range(0, 3));
      rf  = 6'($urandom_range(0, 63));
      rr  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      raf = 4'($urandom_range(0, 15));
      run_instr(rc, ro, rf, rr, raf, -1, -1, ncyc, last);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
